// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// the transaction state type and request error classification.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Illegal width code, misalignment and out-of-range all collapse onto one flag.
    function automatic logic reqIsError(input logic        isWrite,
                                        input logic [31:0] addr,
                                        input logic [2:0]  func3,
                                        input logic [31:0] depthWords);
        logic illegal;
        logic misaligned;
        logic outOfRange;
        if (isWrite) begin
            illegal = !(func3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                     ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        outOfRange = ({2'b00, addr[31:2]} >= depthWords);
        return illegal || misaligned || outOfRange;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting between right-aligned core data and the 32-bit RAM word:
// store byte enables plus lane replication, and load extraction with extension.
module dmem_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byteEn_o,
    output logic [31:0] wdataLanes_o,
    output logic [31:0] loadData_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = 8'h00;
        case (addrLo_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
    end

    assign halfSel = addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Replicating the store data lets the byte enables alone pick the lane.
    always_comb begin
        byteEn_o     = 4'b0000;
        wdataLanes_o = 32'h0;
        loadData_o   = 32'h0;
        case (func3_i[1:0])
            2'b00: begin
                byteEn_o     = 4'b0001 << addrLo_i;
                wdataLanes_o = {4{wdata_i[7:0]}};
                loadData_o   = func3_i[2] ? {24'h0, byteSel}
                                          : {{24{byteSel[7]}}, byteSel};
            end
            2'b01: begin
                byteEn_o     = addrLo_i[1] ? 4'b1100 : 4'b0011;
                wdataLanes_o = {2{wdata_i[15:0]}};
                loadData_o   = func3_i[2] ? {16'h0, halfSel}
                                          : {{16{halfSel[15]}}, halfSel};
            end
            2'b10: begin
                byteEn_o     = 4'b1111;
                wdataLanes_o = wdata_i;
                loadData_o   = rdata_i;
            end
            default: begin
                byteEn_o     = 4'b0000;
                wdataLanes_o = 32'h0;
                loadData_o   = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the load/store path: one request at a time,
// configurable wait states, RV32I byte/half/word accesses on a word RAM.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            write_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      func3_q;
    logic [31:0]     rspRdata_q;
    logic            rspErr_q;
    logic [31:0]     rspRdata_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            reqErr;
    logic            reqFire;
    logic            commitNow;
    logic            accessWrite;
    logic [AW+1:0]   accessAddr;
    logic [31:0]     accessWdata;
    logic [2:0]      accessFunc3;
    logic [AW-1:0]   wordIdx;
    logic [31:0]     ramWord;
    logic [3:0]      byteEn;
    logic [31:0]     wdataLanes;
    logic [31:0]     loadData;

    assign reqErr  = reqIsError(req_write, req_addr, req_func3, 32'(DEPTH_WORDS));
    assign reqFire = reset && (state_q == IDLE) && req_valid;

    // With no wait states the access commits on the accept edge, before the
    // request registers hold it, so the live request fields are used instead.
    assign accessWrite = (state_q == IDLE) ? req_write            : write_q;
    assign accessAddr  = (state_q == IDLE) ? req_addr[AW+1:0]     : addr_q;
    assign accessWdata = (state_q == IDLE) ? req_wdata            : wdata_q;
    assign accessFunc3 = (state_q == IDLE) ? req_func3            : func3_q;

    assign commitNow = reset &&
                       ((reqFire && !reqErr && ZERO_WAIT) ||
                        ((state_q == WAIT) && (cnt_q == 4'd0)));

    assign wordIdx = accessAddr[AW+1:2];
    assign ramWord = mem[wordIdx];

    dmem_lane_fmt u_lane_fmt (
        .func3_i      (accessFunc3),
        .addrLo_i     (accessAddr[1:0]),
        .wdata_i      (accessWdata),
        .rdata_i      (ramWord),
        .byteEn_o     (byteEn),
        .wdataLanes_o (wdataLanes),
        .loadData_o   (loadData)
    );

    assign rspRdata_d = accessWrite ? 32'h0 : loadData;

    // RAM contents survive reset; only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (commitNow && accessWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wdataLanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            func3_q    <= 3'b000;
            rspRdata_q <= 32'h0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        func3_q <= req_func3;
                        if (reqErr) begin
                            rspErr_q   <= 1'b1;
                            rspRdata_q <= 32'h0;
                            state_q    <= RESP;
                        end else if (ZERO_WAIT) begin
                            rspErr_q   <= 1'b0;
                            rspRdata_q <= rspRdata_d;
                            state_q    <= RESP;
                        end else begin
                            cnt_q   <= WAIT_LOAD;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rspErr_q   <= 1'b0;
                        rspRdata_q <= rspRdata_d;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as reset is held, not just after an edge.
    assign req_ready = reset && (state_q == IDLE);
    assign rsp_valid = reset && (state_q == RESP);
    assign rsp_err   = reset && rspErr_q;
    assign rsp_rdata = reset ? rspRdata_q : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder against a byte-addressed
// reference memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          nAsserts = 0;
    int          nFails   = 0;
    logic [31:0] lastRdata;
    logic [7:0]  refMem [int];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_func3 (req_func3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: little-endian byte memory, width = 1 << func3[1:0].
    function automatic void modelAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                                        input logic [2:0] f3, output logic err, output logic [31:0] rdata);
        int          size;
        logic        legal;
        logic [31:0] val;
        legal = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        size  = 1 << f3[1:0];
        err   = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
        rdata = 32'h0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < size; i++) refMem[int'(a) + i] = d[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = refMem[int'(a) + i];
                if (!f3[2] && (size < 4) && val[8*size-1]) begin
                    for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
                end
                rdata = val;
            end
        end
    endfunction

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f3, input int hold, input string tag);
        logic        expErr;
        logic [31:0] expData;
        int          lat;
        int          expLat;
        modelAccess(w, a, d, f3, expErr, expData);
        expLat = expErr ? 1 : WAITC + 1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_func3 = f3;
        rsp_ready = 1'b0;
        checkOutput({tag, ".readyIdle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                checkOutput({tag, ".readyBusy"}, 32'(req_ready), 32'd0);
            end
        end while (!rsp_valid && lat < 20);
        lastRdata = rsp_rdata;
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".err"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, ".rdata"}, rsp_rdata, expData);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, ".holdValid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".holdRdata"}, rsp_rdata, expData);
            checkOutput({tag, ".holdReady"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, ".readyAfter"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".validAfter"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_func3 = 3'b000;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst.reqReady", 32'(req_ready), 32'd0);
        checkOutput("rst.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rst.rspErr", 32'(rsp_err), 32'd0);
        checkOutput("rst.rspRdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst.readyFirst", 32'(req_ready), 32'd1);

        // Give every word the bench will read a known value.
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 32'(4 * i), $urandom, 3'b010, 0, "init");

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, "sw10");
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 0, "lw10");
        checkOutput("plan.lw10", lastRdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h11, 32'h0000007F, 3'b000, 0, "sb11");
        applyStimulus(1'b0, 32'h11, 32'h0, 3'b000, 0, "lb11");
        checkOutput("plan.lb11", lastRdata, 32'h0000007F);
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 5, "lw10bp");
        checkOutput("plan.lw10bp", lastRdata, 32'hDEAD7FEF);
        applyStimulus(1'b0, 32'h13, 32'h0, 3'b100, 0, "lbu13");
        checkOutput("plan.lbu13", lastRdata, 32'h000000DE);
        applyStimulus(1'b0, 32'h13, 32'h0, 3'b000, 0, "lb13");
        checkOutput("plan.lb13", lastRdata, 32'hFFFFFFDE);
        applyStimulus(1'b1, 32'h22, 32'h00008001, 3'b001, 0, "sh22");
        applyStimulus(1'b0, 32'h22, 32'h0, 3'b001, 0, "lh22");
        checkOutput("plan.lh22", lastRdata, 32'hFFFF8001);
        applyStimulus(1'b0, 32'h22, 32'h0, 3'b101, 0, "lhu22");
        checkOutput("plan.lhu22", lastRdata, 32'h00008001);
        applyStimulus(1'b0, 32'h21, 32'h0, 3'b001, 1, "lh21mis");
        applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 0, "lw20");
        checkOutput("plan.lw20hi", {16'h0, lastRdata[31:16]}, 32'h00008001);
        applyStimulus(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 3'b010, 0, "swOor");
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 0, "lw0");
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b011, 0, "f3ill");

        // Store aborted by reset during its wait states must never reach the RAM.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_func3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("rstWait.reqReady", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("rstWait.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstWait.rspErr", 32'(rsp_err), 32'd0);
        checkOutput("rstWait.rspRdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstWait.readyFirst", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 32'h30, 32'h0, 3'b010, 0, "lw30");

        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0 && !w) f3 = 3'($urandom_range(4, 5));
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            applyStimulus(w, a, $urandom, f3, int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's load/store path. Accepts one request at a time over a valid/ready handshake, applies a configurable number of wait states, and performs RV32I byte/half/word accesses selected by func3 against a word-organised RAM. Returns a response with sign- or zero-extended load data and an error flag. It allows the core's memory stage to be exercised against realistic multi-cycle data memory instead of a single-cycle array.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, ≥ 4
- WAIT_CYCLES, 1, extra cycles between request acceptance and access commit; 0..15
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_func3  input  3  RV32I width/sign code
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester takes response
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range or illegal func3

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr, wdata and func3.
  - If the request is erroneous → RESP with rsp_err=1. No RAM write.
  - Else if WAIT_CYCLES==0 → commit the access this cycle → RESP.
  - Else load the counter with WAIT_CYCLES-1 → WAIT.
- WAIT: req_ready=0. Decrement the counter. When it is 0, commit the access → RESP.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_ready. On rsp_ready → IDLE.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other func3 is an error.
- Misaligned: half-word access with addr[0]=1, or word access with addr[1:0]≠0.
- Out of range: addr[31:2] ≥ DEPTH_WORDS.
- Error priority: illegal func3 > misaligned > out of range. All three set the same flag.
- Store commit writes only the selected byte lanes. Byte lane = addr[1:0]. Half lane = addr[1]. Other lanes are unchanged.
- Load: extract the lane, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Load data is captured at commit into a response register. A later store cannot change a response that is already pending.
- Reset: state=IDLE, counter=0. req_ready, rsp_valid, rsp_err and rsp_rdata are all 0 while reset=0. RAM contents are not cleared.
- Reset asserted in WAIT or RESP drops the transaction. A pending store that has not yet committed is discarded.

## Timing
- Request handshake at edge T.
- Commit occurs at edge T+WAIT_CYCLES. For WAIT_CYCLES=0, commit is at edge T itself (same edge as acceptance).
- rsp_valid is first high in the cycle after edge T+WAIT_CYCLES.
- Errors skip WAIT: rsp_valid is high in the cycle after edge T, regardless of WAIT_CYCLES.
- req_ready returns to 1 in the cycle after the response handshake. There is no request/response overlap; throughput is one transaction per WAIT_CYCLES+2 cycles minimum.
- req_valid may be held across non-ready cycles. The request is sampled only at the handshake edge.
- rsp_ready held high is legal: RESP lasts exactly one cycle.
- First cycle after reset deasserts: req_ready=1.

## Structure
- Shared package mem_pkg:
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum {IDLE, WAIT, RESP}
  - the error-classification function
- One sub-module, dmem_lane_fmt (combinational), performs two jobs:
  - store side: byte-enable generation and lane replication of wdata
  - load side: lane extraction with sign or zero extension
- RAM is an inferred synchronous-write array inside data_mem_responder. Reads use the latched address at commit.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF @0x10 then LW @0x10 → rsp_rdata=0xDEADBEEF. rsp_valid first high 3 cycles after each request handshake. rsp_err=0.
- After the above: SB 0x7F @0x11, then LB @0x11 → 0x0000007F. LW @0x10 → 0xDEAD7FEF. LBU @0x13 → 0x000000DE. LB @0x13 → 0xFFFFFFDE.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001 and LHU @0x22 → 0x00008001. LH @0x21 → rsp_err=1 and rsp_rdata=0, valid 1 cycle after accept. A following LW @0x20 shows the upper half is still 0x8001.
- Out-of-range SW at byte address 4*DEPTH_WORDS → rsp_err=1. A subsequent LW @0x0 returns unchanged data. func3=011 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable and req_ready=0 throughout. Raise rsp_ready → req_ready=1 next cycle.
- Reset: assert reset=0 during WAIT of SW 0x12345678 @0x30 → all outputs 0 and state IDLE. Then LW @0x30 → old value returned; the store did not commit.
